// File: rtl/embcpumem_mem_tester.sv
// ---------------------------------------------------------------------------
// embcpumem_mem_tester
//
// Built-in memory tester for an on-chip RAM on a fixed-latency Avalon-MM
// slave. A run writes an incrementing pattern (seed+i) to count consecutive
// word addresses (base+i). It then reads the same words back and compares
// each returned word against the pattern, READ_LATENCY cycles after the read.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 run request, only looked at in IDLE
//   base, count, seed     run parameters, captured with an accepted start
//   busy                  high in WRITE, READ and DRAIN
//   done                  one-cycle pulse in FIN
//   error                 sticky mismatch flag for the current run
//   err_addr              address of the first mismatching word
//   err_count             mismatch count, saturates at 16'hFFFF
//   avm_*                 Avalon-MM master towards the memory
//   dbg_state             current FSM state (state_t encoding)
//
// Bus protocol: the slave has no waitrequest. Every cycle with
// avm_chipselect=1 is one complete access: a write when avm_write=1, a read
// when avm_write=0. Read data for a read issued in cycle t appears on
// avm_readdata during cycle t+READ_LATENCY. The tester samples it at the
// rising edge that ends that cycle.
//
// All outputs are decoded from registered state only. A reset therefore
// drives every output to its idle value immediately, without a clock edge.
// ---------------------------------------------------------------------------
module embcpumem_mem_tester #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base,
  input  logic [ADDR_W:0]       count,
  input  logic [DATA_W-1:0]     seed,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_W-1:0]     err_addr,
  output logic [15:0]           err_count,
  output logic [ADDR_W-1:0]     avm_address,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  output logic                  avm_chipselect,
  output logic                  avm_write,
  output logic [DATA_W-1:0]     avm_writedata,
  input  logic [DATA_W-1:0]     avm_readdata,
  output logic                  avm_clken,
  output logic [2:0]            dbg_state
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  state_t                                  state_q, state_d;
  logic [ADDR_W-1:0]                       base_q, base_d;
  logic [ADDR_W:0]                         count_q, count_d;
  logic [DATA_W-1:0]                       seed_q, seed_d;
  logic [ADDR_W:0]                         idx_q, idx_d;
  logic [2:0]                              drain_q, drain_d;
  logic                                    error_q, error_d;
  logic [ADDR_W-1:0]                       err_addr_q, err_addr_d;
  logic [15:0]                             err_count_q, err_count_d;

  // Expected-data pipeline. Stage 0 is loaded with the read issued this
  // cycle. Stage READ_LATENCY-1 lines up with the slave's returned data.
  logic [READ_LATENCY-1:0]                 pipe_vld_q, pipe_vld_d;
  logic [READ_LATENCY-1:0][ADDR_W-1:0]     pipe_addr_q, pipe_addr_d;
  logic [READ_LATENCY-1:0][DATA_W-1:0]     pipe_data_q, pipe_data_d;

  logic [ADDR_W-1:0]                       acc_addr;
  logic [DATA_W-1:0]                       acc_data;
  logic                                    last_word;
  logic                                    cs;
  logic                                    wr;

  // Address and pattern wrap modulo their widths by plain truncation.
  assign acc_addr  = base_q + idx_q[ADDR_W-1:0];
  assign acc_data  = seed_q + DATA_W'(idx_q);
  assign last_word = (idx_q == (count_q - (ADDR_W+1)'(1)));

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    seed_d      = seed_q;
    idx_d       = idx_q;
    drain_d     = drain_q;
    error_d     = error_q;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    cs          = 1'b0;
    wr          = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    // Advance the expected-data pipeline every cycle.
    pipe_vld_d     = '0;
    pipe_addr_d    = pipe_addr_q;
    pipe_data_d    = pipe_data_q;
    pipe_vld_d[0]  = (state_q == ST_READ);
    pipe_addr_d[0] = acc_addr;
    pipe_data_d[0] = acc_data;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
      pipe_data_d[i] = pipe_data_q[i-1];
    end

    // Compare the word whose read data is on the bus this cycle.
    if (pipe_vld_q[READ_LATENCY-1] &&
        (avm_readdata != pipe_data_q[READ_LATENCY-1])) begin
      error_d = 1'b1;
      if (!error_q) begin
        err_addr_d = pipe_addr_q[READ_LATENCY-1];
      end
      if (err_count_q != 16'hFFFF) begin
        err_count_d = err_count_q + 16'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d      = base;
          count_d     = count;
          seed_d      = seed;
          idx_d       = '0;
          error_d     = 1'b0;
          err_addr_d  = '0;
          err_count_d = '0;
          // An empty run still reports completion, but never touches the bus.
          state_d     = (count == '0) ? ST_FIN : ST_WRITE;
        end
      end
      ST_WRITE: begin
        busy = 1'b1;
        cs   = 1'b1;
        wr   = 1'b1;
        if (last_word) begin
          idx_d   = '0;
          state_d = ST_READ;
        end else begin
          idx_d = idx_q + (ADDR_W+1)'(1);
        end
      end
      ST_READ: begin
        busy = 1'b1;
        cs   = 1'b1;
        if (last_word) begin
          drain_d = '0;
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + (ADDR_W+1)'(1);
        end
      end
      ST_DRAIN: begin
        // Wait until the last read's data has been compared.
        busy = 1'b1;
        if (drain_q == 3'(READ_LATENCY - 1)) begin
          state_d = ST_FIN;
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      count_q     <= '0;
      seed_q      <= '0;
      idx_q       <= '0;
      drain_q     <= '0;
      error_q     <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
      pipe_vld_q  <= '0;
      pipe_addr_q <= '0;
      pipe_data_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      seed_q      <= seed_d;
      idx_q       <= idx_d;
      drain_q     <= drain_d;
      error_q     <= error_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_addr_q <= pipe_addr_d;
      pipe_data_q <= pipe_data_d;
    end
  end

  assign error          = error_q;
  assign err_addr       = err_addr_q;
  assign err_count      = err_count_q;
  assign avm_chipselect = cs;
  assign avm_write      = wr;
  assign avm_address    = cs ? acc_addr : '0;
  assign avm_writedata  = wr ? acc_data : '0;
  assign avm_byteenable = cs ? {BE_W{1'b1}} : {BE_W{1'b0}};
  assign avm_clken      = 1'b1;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_embcpumem_mem_tester.sv
// ---------------------------------------------------------------------------
// tb_embcpumem_mem_tester
//
// Two tester instances share the clock and reset: dut1 with READ_LATENCY=1
// and dut2 with READ_LATENCY=2. Each drives its own slave memory model. The
// model can flip bit 0 of read data, either for one address or for every
// address. Free-running monitors count busy, done, chipselect and write
// cycles. The directed steps compare the change in these counters, and the
// model memory contents, against hand-computed values.
// ---------------------------------------------------------------------------
module tb_embcpumem_mem_tester;

  localparam int AW = 12;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // ---------------- dut1 (latency 1) ----------------
  logic          start1;
  logic [AW-1:0] base1;
  logic [AW:0]   count1;
  logic [DW-1:0] seed1;
  logic          busy1, done1, error1, cs1, wr1, clken1;
  logic [AW-1:0] err_addr1, addr1;
  logic [15:0]   err_count1;
  logic [3:0]    be1;
  logic [DW-1:0] wd1, rdata1;
  logic [2:0]    dbg1;

  embcpumem_mem_tester #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .base(base1),
    .count(count1), .seed(seed1), .busy(busy1), .done(done1),
    .error(error1), .err_addr(err_addr1), .err_count(err_count1),
    .avm_address(addr1), .avm_byteenable(be1), .avm_chipselect(cs1),
    .avm_write(wr1), .avm_writedata(wd1), .avm_readdata(rdata1),
    .avm_clken(clken1), .dbg_state(dbg1)
  );

  // ---------------- dut2 (latency 2) ----------------
  logic          start2;
  logic [AW-1:0] base2;
  logic [AW:0]   count2;
  logic [DW-1:0] seed2;
  logic          busy2, done2, error2, cs2, wr2, clken2;
  logic [AW-1:0] err_addr2, addr2;
  logic [15:0]   err_count2;
  logic [3:0]    be2;
  logic [DW-1:0] wd2, rdata2;
  logic [2:0]    dbg2;

  embcpumem_mem_tester #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .base(base2),
    .count(count2), .seed(seed2), .busy(busy2), .done(done2),
    .error(error2), .err_addr(err_addr2), .err_count(err_count2),
    .avm_address(addr2), .avm_byteenable(be2), .avm_chipselect(cs2),
    .avm_write(wr2), .avm_writedata(wd2), .avm_readdata(rdata2),
    .avm_clken(clken2), .dbg_state(dbg2)
  );

  // ---------------- slave memory models ----------------
  logic [DW-1:0] mem1 [0:4095];
  logic [DW-1:0] mem2 [0:4095];
  logic [DW-1:0] rd1_q;
  logic [DW-1:0] rd2a_q;
  logic [DW-1:0] rd2b_q;
  logic          corrupt_en1 = 1'b0;
  logic [AW-1:0] corrupt_addr1 = '0;
  logic          corrupt_all2 = 1'b0;

  always @(posedge clk) begin
    if (cs1 && wr1) mem1[addr1] <= wd1;
    if (cs1 && !wr1)
      rd1_q <= mem1[addr1] ^ ((corrupt_en1 && addr1 == corrupt_addr1) ? 32'h1 : 32'h0);
  end
  assign rdata1 = rd1_q;

  always @(posedge clk) begin
    if (cs2 && wr2) mem2[addr2] <= wd2;
    rd2a_q <= mem2[addr2] ^ (corrupt_all2 ? 32'h1 : 32'h0);
    rd2b_q <= rd2a_q;
  end
  assign rdata2 = rd2b_q;

  // ---------------- monitors ----------------
  int cnt_busy1 = 0, cnt_done1 = 0, cnt_cs1 = 0, cnt_wr1 = 0, cnt_w200 = 0, cnt_prot1 = 0;
  int cnt_busy2 = 0, cnt_done2 = 0, cnt_cs2 = 0, cnt_prot2 = 0;

  always @(negedge clk) begin
    if (busy1) cnt_busy1 <= cnt_busy1 + 1;
    if (done1) cnt_done1 <= cnt_done1 + 1;
    if (cs1) cnt_cs1 <= cnt_cs1 + 1;
    if (cs1 && wr1) cnt_wr1 <= cnt_wr1 + 1;
    if (cs1 && wr1 && addr1 == 12'h200) cnt_w200 <= cnt_w200 + 1;
    if ((wr1 && !cs1) || (be1 !== (cs1 ? 4'hF : 4'h0)) || (clken1 !== 1'b1))
      cnt_prot1 <= cnt_prot1 + 1;
    if (busy2) cnt_busy2 <= cnt_busy2 + 1;
    if (done2) cnt_done2 <= cnt_done2 + 1;
    if (cs2) cnt_cs2 <= cnt_cs2 + 1;
    if ((wr2 && !cs2) || (be2 !== (cs2 ? 4'hF : 4'h0)) || (clken2 !== 1'b1))
      cnt_prot2 <= cnt_prot2 + 1;
  end

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Snapshots of monitor counters taken before each run.
  int s_busy1, s_done1, s_cs1, s_wr1, s_busy2, s_done2, s_cs2;

  task automatic snap();
    s_busy1 = cnt_busy1; s_done1 = cnt_done1; s_cs1 = cnt_cs1; s_wr1 = cnt_wr1;
    s_busy2 = cnt_busy2; s_done2 = cnt_done2; s_cs2 = cnt_cs2;
  endtask

  // ---------------- driver tasks ----------------
  task automatic run1(input logic [AW-1:0] b, input logic [AW:0] c,
                      input logic [DW-1:0] s, output int cyc);
    @(negedge clk);
    start1 = 1'b1; base1 = b; count1 = c; seed1 = s;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 0;
    while (done1 !== 1'b1 && cyc < 10000) begin
      @(negedge clk);
      cyc++;
    end
    chk("dut1_done_seen", {31'b0, done1}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run2(input logic [AW-1:0] b, input logic [AW:0] c,
                      input logic [DW-1:0] s, output int cyc);
    @(negedge clk);
    start2 = 1'b1; base2 = b; count2 = c; seed2 = s;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 0;
    while (done2 !== 1'b1 && cyc < 10000) begin
      @(negedge clk);
      cyc++;
    end
    chk("dut2_done_seen", {31'b0, done2}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    reset_n = 1'b0;
    start1 = 1'b0; base1 = '0; count1 = '0; seed1 = '0;
    start2 = 1'b0; base2 = '0; count2 = '0; seed2 = '0;

    // Reset values before any clock edge.
    #3;
    chk("rst_busy",   {31'b0, busy1}, 32'd0);
    chk("rst_done",   {31'b0, done1}, 32'd0);
    chk("rst_error",  {31'b0, error1}, 32'd0);
    chk("rst_cs",     {31'b0, cs1}, 32'd0);
    chk("rst_addr",   {20'b0, addr1}, 32'd0);
    chk("rst_be",     {28'b0, be1}, 32'd0);
    chk("rst_state",  {29'b0, dbg1}, 32'd0);
    chk("rst_clken",  {31'b0, clken1}, 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean 4-word run at latency 1.
    snap();
    run1(12'h010, 13'd4, 32'hA5A5_0000, cyc);
    chk("t1_cycles",   cyc, 32'd9);
    chk("t1_busy",     cnt_busy1 - s_busy1, 32'd9);
    chk("t1_done",     cnt_done1 - s_done1, 32'd1);
    chk("t1_cs",       cnt_cs1 - s_cs1, 32'd8);
    chk("t1_writes",   cnt_wr1 - s_wr1, 32'd4);
    chk("t1_mem010",   mem1[12'h010], 32'hA5A5_0000);
    chk("t1_mem011",   mem1[12'h011], 32'hA5A5_0001);
    chk("t1_mem012",   mem1[12'h012], 32'hA5A5_0002);
    chk("t1_mem013",   mem1[12'h013], 32'hA5A5_0003);
    chk("t1_error",    {31'b0, error1}, 32'd0);
    chk("t1_errcnt",   {16'b0, err_count1}, 32'd0);

    // Same run, word 0x012 corrupted on read.
    corrupt_addr1 = 12'h012;
    corrupt_en1   = 1'b1;
    run1(12'h010, 13'd4, 32'hA5A5_0000, cyc);
    corrupt_en1   = 1'b0;
    chk("t2_error",    {31'b0, error1}, 32'd1);
    chk("t2_erraddr",  {20'b0, err_addr1}, 32'h012);
    chk("t2_errcnt",   {16'b0, err_count1}, 32'd1);
    repeat (3) @(negedge clk);
    chk("t2_sticky",   {31'b0, error1}, 32'd1);

    // Empty run: done one cycle after start, no bus, error cleared.
    snap();
    run1(12'h020, 13'd0, 32'h0, cyc);
    chk("t3_cycles",   cyc, 32'd0);
    chk("t3_busy",     cnt_busy1 - s_busy1, 32'd0);
    chk("t3_cs",       cnt_cs1 - s_cs1, 32'd0);
    chk("t3_done",     cnt_done1 - s_done1, 32'd1);
    chk("t3_error",    {31'b0, error1}, 32'd0);

    // Address and pattern wrap.
    run1(12'hFFE, 13'd4, 32'hFFFF_FFFE, cyc);
    chk("t4_memFFE",   mem1[12'hFFE], 32'hFFFF_FFFE);
    chk("t4_memFFF",   mem1[12'hFFF], 32'hFFFF_FFFF);
    chk("t4_mem000",   mem1[12'h000], 32'h0000_0000);
    chk("t4_mem001",   mem1[12'h001], 32'h0000_0001);
    chk("t4_error",    {31'b0, error1}, 32'd0);

    // Second start while busy is ignored; reset during READ aborts the run.
    snap();
    @(negedge clk);
    start1 = 1'b1; base1 = 12'h100; count1 = 13'd8; seed1 = 32'h1234_5678;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    start1 = 1'b1; base1 = 12'h200; count1 = 13'd1; seed1 = 32'h0;
    @(negedge clk);
    start1 = 1'b0;
    repeat (6) @(negedge clk);
    chk("t5_in_read0", {29'b0, dbg1}, 32'd2);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_busy",  {31'b0, busy1}, 32'd0);
    chk("t5_rst_cs",    {31'b0, cs1}, 32'd0);
    chk("t5_rst_wr",    {31'b0, wr1}, 32'd0);
    chk("t5_rst_addr",  {20'b0, addr1}, 32'd0);
    chk("t5_rst_wdata", wd1, 32'd0);
    chk("t5_rst_be",    {28'b0, be1}, 32'd0);
    chk("t5_rst_state", {29'b0, dbg1}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_writes",   cnt_wr1 - s_wr1, 32'd8);
    chk("t5_cs",       cnt_cs1 - s_cs1, 32'd10);
    chk("t5_busy",     cnt_busy1 - s_busy1, 32'd10);
    chk("t5_no_done",  cnt_done1 - s_done1, 32'd0);
    chk("t5_w200",     cnt_w200, 32'd0);
    chk("t5_mem100",   mem1[12'h100], 32'h1234_5678);
    chk("t5_mem107",   mem1[12'h107], 32'h1234_567F);
    chk("t5_idle",     {31'b0, busy1}, 32'd0);

    // Latency 2: clean 4-word run, then a full-memory run with every read corrupted.
    snap();
    run2(12'h010, 13'd4, 32'hA5A5_0000, cyc);
    chk("t6_cycles",   cyc, 32'd10);
    chk("t6_busy",     cnt_busy2 - s_busy2, 32'd10);
    chk("t6_cs",       cnt_cs2 - s_cs2, 32'd8);
    chk("t6_error",    {31'b0, error2}, 32'd0);
    chk("t6_mem013",   mem2[12'h013], 32'hA5A5_0003);

    snap();
    corrupt_all2 = 1'b1;
    run2(12'h123, 13'd4096, 32'h0, cyc);
    corrupt_all2 = 1'b0;
    chk("t7_cycles",   cyc, 32'd8194);
    chk("t7_busy",     cnt_busy2 - s_busy2, 32'd8194);
    chk("t7_done",     cnt_done2 - s_done2, 32'd1);
    chk("t7_error",    {31'b0, error2}, 32'd1);
    chk("t7_erraddr",  {20'b0, err_addr2}, 32'h123);
    chk("t7_errcnt",   {16'b0, err_count2}, 32'd4096);
    chk("t7_mem122",   mem2[12'h122], 32'h0000_0FFF);

    chk("prot1",       cnt_prot1, 32'd0);
    chk("prot2",       cnt_prot2, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/embcpumem_mem_tester.md
EMBCPUMEM_MEM_TESTER -- requirements
Module: embcpumem_mem_tester

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 12, word-address width of the target memory.
REQ-002 The module SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 The module SHALL have parameter READ_LATENCY, default 1, fixed slave read latency in cycles (1..4).
REQ-004 The module SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  single-cycle run request; sampled only in IDLE.
REQ-008 base  input  ADDR_W  first word address; sampled with start.
REQ-009 count  input  ADDR_W+1  number of words, 0..2^ADDR_W; sampled with start.
REQ-010 seed  input  DATA_W  pattern seed; sampled with start.
REQ-011 busy  output  1  high while a run is in progress.
REQ-012 done  output  1  one-cycle pulse at end of run.
REQ-013 error  output  1  sticky mismatch flag, cleared on accepted start.
REQ-014 err_addr  output  ADDR_W  address of first mismatch in the current run.
REQ-015 err_count  output  16  saturating mismatch count for the current run.
REQ-016 avm_address  output  ADDR_W  master word address.
REQ-017 avm_byteenable  output  DATA_W/8  all ones whenever avm_chipselect is high, else zero.
REQ-018 avm_chipselect  output  1  access valid.
REQ-019 avm_write  output  1  write strobe; read when low with avm_chipselect high.
REQ-020 avm_writedata  output  DATA_W  write data.
REQ-021 avm_readdata  input  DATA_W  slave read data, valid READ_LATENCY cycles after the read cycle.
REQ-022 avm_clken  output  1  constant 1 (slave clock enable).

Function
REQ-023 The FSM SHALL have states IDLE, WRITE, READ, DRAIN, FIN.
REQ-024 IDLE, start=1, count>0: register base/count/seed, clear error/err_addr/err_count, go to WRITE.
REQ-025 IDLE, start=1, count=0: go to FIN without any bus access; error clears.
REQ-026 start SHALL be ignored in every state other than IDLE.
REQ-027 Word i (0..count-1) SHALL use address (base+i) mod 2^ADDR_W and pattern (seed+i) mod 2^DATA_W.
REQ-028 WRITE: one write per cycle (chipselect=1, write=1), i ascending; after word count-1 go to READ.
REQ-029 READ: one read per cycle (chipselect=1, write=0), i ascending; after word count-1 go to DRAIN.
REQ-030 An expected-data/address pipeline of depth READ_LATENCY SHALL track each read; avm_readdata SHALL be compared at exactly READ_LATENCY cycles after its read cycle.
REQ-031 On mismatch: set error; if first mismatch of the run, load err_addr; increment err_count, saturating at 0xFFFF.
REQ-032 DRAIN SHALL last READ_LATENCY cycles with chipselect=0, then go to FIN.
REQ-033 FIN SHALL last one cycle with done=1 and busy=0, then go to IDLE.
REQ-034 busy SHALL be 1 in WRITE, READ, DRAIN; a run of N>0 words holds busy for 2N+READ_LATENCY cycles.
REQ-035 chipselect SHALL be 0 in IDLE, DRAIN, FIN; avm_write SHALL be 0 whenever chipselect is 0.
REQ-036 Address wrap past 2^ADDR_W-1 to 0 SHALL be silent; pattern wrap past 2^DATA_W-1 likewise.

Reset
REQ-037 On reset_n low, state SHALL be IDLE and busy, done, error, err_addr, err_count, avm_chipselect, avm_write, avm_address, avm_writedata and avm_byteenable SHALL all be 0, immediately and without a clock edge.
REQ-038 Reset asserted mid-run SHALL abort the run with no further bus access; no done pulse occurs.

Verification
REQ-039 base=0x010, count=4, seed=0xA5A50000, model memory correct, latency 1 -> writes 0xA5A50000..0xA5A50003 at 0x010..0x013, 4 reads, busy 9 cycles, done, error=0.
REQ-040 Same run, model corrupts word 0x012 on read -> error=1, err_addr=0x012, err_count=1.
REQ-041 base=0xFFE, count=4, seed=0xFFFFFFFE -> addresses 0xFFE,0xFFF,0x000,0x001; data 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1; error=0.
REQ-042 count=0 -> no chipselect, done one cycle after start, busy never high.
REQ-043 start pulsed again while busy, then reset_n low during READ -> second start ignored; reset forces all outputs to 0 immediately with no done pulse.
REQ-044 count=4096, all reads corrupted, READ_LATENCY=2 -> err_addr=base, err_count=4096, busy 8194 cycles.
